// File: rtl/uart_rx_flow_ctrl.sv
// UART receive FIFO with RTS watermark flow control,
// sticky overrun, saturating error count and level interrupt.
module uart_rx_flow_ctrl #(
    parameter int DEPTH  = 16,
    parameter int RTS_HI = 12,
    parameter int RTS_LO = 4,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cfg_rx_en_i,
    output logic          rx_en_o,
    output logic          rts_no,
    input  logic [7:0]    rx_data_i,
    input  logic          rx_valid_i,
    input  logic          parity_err_i,
    input  logic          stop_bit_err_i,
    input  logic          rd_en_i,
    output logic [7:0]    rd_data_o,
    output logic          rd_perr_o,
    output logic          rd_ferr_o,
    input  logic          flush_i,
    output logic [AW:0]   count_o,
    output logic          empty_o,
    output logic          full_o,
    output logic          overrun_o,
    input  logic          clr_overrun_i,
    output logic [7:0]    err_cnt_o,
    input  logic          clr_err_i,
    input  logic [AW:0]   irq_level_i,
    output logic          irq_o
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] HI_CNT   = (AW+1)'(RTS_HI);
    localparam logic [AW:0] LO_CNT   = (AW+1)'(RTS_LO);

    typedef enum logic [1:0] {
        OFF       = 2'd0,
        READY     = 2'd1,
        THROTTLED = 2'd2
    } rts_state_t;

    rts_state_t    state_q;
    rts_state_t    state_d;
    logic [9:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [9:0]    head;
    logic          pop;
    logic          accept;
    logic          drop;
    logic          frame_err;

    assign empty_o   = (count_o == '0);
    assign full_o    = (count_o == FULL_CNT);
    assign pop       = rd_en_i & ~empty_o & ~flush_i;
    assign accept    = rx_valid_i & rx_en_o & ~flush_i & (~full_o | pop);
    assign drop      = rx_valid_i & rx_en_o & full_o & ~pop & ~flush_i;
    assign frame_err = parity_err_i | stop_bit_err_i;

    assign head      = mem[rd_ptr];
    assign rd_data_o = empty_o ? 8'h00 : head[7:0];
    assign rd_perr_o = ~empty_o & head[8];
    assign rd_ferr_o = ~empty_o & head[9];
    assign rts_no    = (state_q != READY);

    // Storage array; contents survive reset and flush
    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= {stop_bit_err_i, parity_err_i, rx_data_i};
    end

    // Pointers and occupancy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else if (flush_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            if (accept && !pop)      count_o <= count_o + 1'b1;
            else if (pop && !accept) count_o <= count_o - 1'b1;
        end
    end

    // Receiver enable, sticky overrun and saturating error count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_en_o   <= 1'b0;
            overrun_o <= 1'b0;
            err_cnt_o <= '0;
        end else begin
            rx_en_o <= cfg_rx_en_i;
            if (drop)               overrun_o <= 1'b1;
            else if (clr_overrun_i) overrun_o <= 1'b0;
            if (clr_err_i)
                err_cnt_o <= '0;
            else if (accept && frame_err && err_cnt_o != 8'hFF)
                err_cnt_o <= err_cnt_o + 1'b1;
        end
    end

    // Registered interrupt from overrun, level and head error
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) irq_o <= 1'b0;
        else irq_o <= overrun_o
                    | ((irq_level_i != '0) & (count_o >= irq_level_i))
                    | (~empty_o & (rd_perr_o | rd_ferr_o));
    end

    // RTS state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= OFF;
        else          state_q <= state_d;
    end

    // RTS next state with watermark hysteresis
    always_comb begin
        state_d = state_q;
        if (!rx_en_o) begin
            state_d = OFF;
        end else begin
            unique case (state_q)
                OFF:       state_d = (count_o < HI_CNT) ? READY : THROTTLED;
                READY:     if (count_o >= HI_CNT) state_d = THROTTLED;
                THROTTLED: if (count_o <= LO_CNT) state_d = READY;
                default:   state_d = OFF;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_flow_ctrl.sv
// Scoreboard bench for uart_rx_flow_ctrl: stimulus queues
// expected FIFO entries, a monitor checks them as they pop.
module tb_uart_rx_flow_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cfg_rx_en_i = 1'b0;
    logic       rx_en_o;
    logic       rts_no;
    logic [7:0] rx_data_i = '0;
    logic       rx_valid_i = 1'b0;
    logic       parity_err_i = 1'b0;
    logic       stop_bit_err_i = 1'b0;
    logic       rd_en_i = 1'b0;
    logic [7:0] rd_data_o;
    logic       rd_perr_o;
    logic       rd_ferr_o;
    logic       flush_i = 1'b0;
    logic [4:0] count_o;
    logic       empty_o;
    logic       full_o;
    logic       overrun_o;
    logic       clr_overrun_i = 1'b0;
    logic [7:0] err_cnt_o;
    logic       clr_err_i = 1'b0;
    logic [4:0] irq_level_i = '0;
    logic       irq_o;

    int errors = 0;
    int checks = 0;
    logic [9:0] exp_q[$];

    uart_rx_flow_ctrl dut (
        .clk(clk), .reset_n(reset_n),
        .cfg_rx_en_i(cfg_rx_en_i), .rx_en_o(rx_en_o),
        .rts_no(rts_no), .rx_data_i(rx_data_i),
        .rx_valid_i(rx_valid_i), .parity_err_i(parity_err_i),
        .stop_bit_err_i(stop_bit_err_i), .rd_en_i(rd_en_i),
        .rd_data_o(rd_data_o), .rd_perr_o(rd_perr_o),
        .rd_ferr_o(rd_ferr_o), .flush_i(flush_i),
        .count_o(count_o), .empty_o(empty_o), .full_o(full_o),
        .overrun_o(overrun_o), .clr_overrun_i(clr_overrun_i),
        .err_cnt_o(err_cnt_o), .clr_err_i(clr_err_i),
        .irq_level_i(irq_level_i), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: whenever a pop is presented, compare the head entry
    always @(negedge clk) begin
        if (reset_n && rd_en_i && !flush_i && !empty_o) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_head: got 0x%0h expected none",
                         {rd_ferr_o, rd_perr_o, rd_data_o});
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                if ({rd_ferr_o, rd_perr_o, rd_data_o} != e) begin
                    errors++;
                    $display("FAIL pop_head: got 0x%0h expected 0x%0h",
                             {rd_ferr_o, rd_perr_o, rd_data_o}, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        rx_valid_i     = 1'b0;
        parity_err_i   = 1'b0;
        stop_bit_err_i = 1'b0;
        rd_en_i        = 1'b0;
        flush_i        = 1'b0;
        clr_overrun_i  = 1'b0;
        clr_err_i      = 1'b0;
    endtask

    // Drive one frame; expected entry queued only when it should land
    task automatic send(input logic [7:0] d, input logic pe,
                        input logic fe, input logic rd, input logic keep);
        rx_valid_i     = 1'b1;
        rx_data_i      = d;
        parity_err_i   = pe;
        stop_bit_err_i = fe;
        rd_en_i        = rd;
        if (keep) exp_q.push_back({fe, pe, d});
        tick();
    endtask

    task automatic pop_n(input int n);
        for (int i = 0; i < n; i++) begin
            rd_en_i = 1'b1;
            tick();
        end
    endtask

    initial begin
        #12;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk("rst_rx_en", rx_en_o, 0);
        chk("rst_rts", rts_no, 1);
        chk("rst_count", count_o, 0);
        chk("rst_empty", empty_o, 1);
        chk("rst_full", full_o, 0);
        chk("rst_overrun", overrun_o, 0);
        chk("rst_err_cnt", err_cnt_o, 0);
        chk("rst_irq", irq_o, 0);
        chk("rst_rd_data", rd_data_o, 0);

        // Watermark hysteresis
        cfg_rx_en_i = 1'b1;
        tick();
        chk("en_rx_en", rx_en_o, 1);
        chk("en_rts_1cyc", rts_no, 1);
        tick();
        chk("en_rts_2cyc", rts_no, 0);
        for (int i = 1; i <= 12; i++) send(8'(i), 0, 0, 0, 1);
        chk("hi_count", count_o, 12);
        chk("hi_rts_same", rts_no, 0);
        tick();
        chk("hi_rts_next", rts_no, 1);
        pop_n(8);
        chk("lo_count", count_o, 4);
        chk("lo_rts_same", rts_no, 1);
        tick();
        chk("lo_rts_next", rts_no, 0);
        pop_n(4);
        chk("drain_empty", empty_o, 1);

        // Overrun on a full FIFO
        for (int i = 1; i <= 16; i++) send(8'(i), 0, 0, 0, 1);
        chk("fill_full", full_o, 1);
        send(8'hAA, 0, 0, 0, 0);
        chk("ovr_set", overrun_o, 1);
        chk("ovr_count", count_o, 16);
        tick();
        chk("ovr_irq", irq_o, 1);
        pop_n(16);
        chk("ovr_drain", empty_o, 1);
        clr_overrun_i = 1'b1;
        tick();
        chk("ovr_clr", overrun_o, 0);
        tick();
        chk("ovr_irq_clr", irq_o, 0);

        // Push and pop together while full
        for (int i = 1; i <= 16; i++) send(8'(i), 0, 0, 0, 1);
        send(8'h55, 0, 0, 1, 1);
        chk("fullrw_count", count_o, 16);
        chk("fullrw_ovr", overrun_o, 0);
        pop_n(15);
        chk("fullrw_last", rd_data_o, 8'h55);
        pop_n(1);

        // Error flags and saturating counter
        send(8'h3C, 1, 0, 0, 1);
        chk("perr_head", rd_perr_o, 1);
        chk("perr_cnt", err_cnt_o, 1);
        tick();
        chk("perr_irq", irq_o, 1);
        pop_n(1);
        for (int i = 0; i < 300; i++) begin
            send(8'(i), 0, 1, 0, 1);
            pop_n(1);
        end
        chk("err_sat", err_cnt_o, 255);
        clr_err_i = 1'b1;
        tick();
        chk("err_clr", err_cnt_o, 0);

        // Flush with a coincident frame
        for (int i = 0; i < 5; i++) send(8'h20 + 8'(i), 0, 0, 0, 1);
        chk("pre_flush", count_o, 5);
        flush_i = 1'b1;
        send(8'hEE, 0, 0, 0, 0);
        exp_q.delete();
        chk("flush_count", count_o, 0);
        chk("flush_empty", empty_o, 1);
        chk("flush_ovr", overrun_o, 0);
        chk("flush_data", rd_data_o, 0);

        // Level interrupt
        irq_level_i = 5'd3;
        for (int i = 0; i < 3; i++) send(8'h40 + 8'(i), 0, 0, 0, 1);
        chk("lvl_irq_pre", irq_o, 0);
        tick();
        chk("lvl_irq", irq_o, 1);
        irq_level_i = '0;
        flush_i = 1'b1;
        tick();
        exp_q.delete();

        // Asynchronous reset mid-operation
        for (int i = 0; i < 12; i++) send(8'h60 + 8'(i), 0, 0, 0, 1);
        tick();
        pop_n(5);
        chk("pre_rst_count", count_o, 7);
        chk("pre_rst_rts", rts_no, 1);
        #2;
        reset_n = 1'b0;
        #1;
        exp_q.delete();
        chk("arst_count", count_o, 0);
        chk("arst_rts", rts_no, 1);
        chk("arst_rx_en", rx_en_o, 0);
        chk("arst_empty", empty_o, 1);
        chk("arst_data", rd_data_o, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk("rel_rx_en", rx_en_o, 0);
        tick();
        chk("rel_rx_en_on", rx_en_o, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_flow_ctrl.md
# uart_rx_flow_ctrl

Receive-side buffer and flow controller placed between the UART receiver and the APB register block. It gates the receiver enable and captures each completed frame with its parity and stop-bit error flags into a first-word-fall-through FIFO. It drives active-low RTS with watermark hysteresis. It also keeps a sticky overrun flag, a saturating error counter and a level interrupt for the APB side.

## Interface
- DEPTH, 16, FIFO entries; power of two, at least 4.
- RTS_HI, 12, count at or above which RTS is deasserted; RTS_LO < RTS_HI <= DEPTH.
- RTS_LO, 4, count at or below which RTS is reasserted.
- AW, $clog2(DEPTH), pointer width (derived).

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset; asynchronous, active-low.
- cfg_rx_en_i  in  1  software receive enable.
- rx_en_o  out  1  enable to receiver; registered copy of cfg_rx_en_i.
- rts_no  out  1  active-low ready-to-receive to receiver and pin.
- rx_data_i  in  8  received byte, right-justified.
- rx_valid_i  in  1  single-cycle frame-complete pulse.
- parity_err_i, stop_bit_err_i  in  1 each  error flags for the frame; valid with rx_valid_i.
- rd_en_i  in  1  pop strobe from the register block.
- rd_data_o  out  8  head byte; 0 when empty.
- rd_perr_o, rd_ferr_o  out  1 each  head entry parity and stop-bit error; 0 when empty.
- flush_i  in  1  synchronous FIFO clear.
- count_o  out  AW+1  occupancy.
- empty_o, full_o  out  1 each  count_o==0 and count_o==DEPTH.
- overrun_o  out  1  sticky: a frame was dropped.
- clr_overrun_i  in  1  clears overrun_o.
- err_cnt_o  out  8  saturating count of accepted frames with any error.
- clr_err_i  in  1  clears err_cnt_o.
- irq_level_i  in  AW+1  interrupt threshold; 0 disables the level term.
- irq_o  out  1  registered interrupt.

## Operation
- Storage is DEPTH x 10 bits {ferr, perr, data}. Pointers are AW bits and wrap modulo DEPTH. count_o is a separate AW+1 register.
- accept = rx_valid_i & rx_en_o & ~flush_i & (~full_o | pop).
- pop = rd_en_i & ~empty_o & ~flush_i.
- The head is read combinationally from rd_ptr (FWFT). Outputs are forced to 0 when empty.
- Push only: wr_ptr+1, count+1. Pop only: rd_ptr+1, count-1. Both in one cycle: both pointers advance and count is unchanged. This holds when full: a pop and a push in the same cycle while full are both accepted.
- rd_en_i while empty is ignored: no pointer change, no error.
- Overrun: rx_valid_i & rx_en_o & full_o & ~pop & ~flush_i drops the frame and sets overrun_o. If set and clr_overrun_i occur together, set wins.
- rx_valid_i while rx_en_o=0 is ignored silently; overrun and error counter are not touched.
- flush_i: pointers and count go to 0; a concurrent rx_valid_i is discarded without setting overrun; overrun_o and err_cnt_o are unchanged.
- err_cnt_o increments on each accepted frame with perr|ferr and saturates at 255. clr_err_i wins over a same-cycle increment.
- RTS state machine:
  - States: OFF (rts_no=1), READY (rts_no=0), THROTTLED (rts_no=1). Transitions are evaluated on registered count_o.
  - OFF -> READY when rx_en_o=1 and count_o < RTS_HI; otherwise OFF -> THROTTLED when rx_en_o=1.
  - READY -> THROTTLED when count_o >= RTS_HI.
  - THROTTLED -> READY when count_o <= RTS_LO.
  - Any state -> OFF when rx_en_o=0.
- irq_o next = overrun_o | (irq_level_i != 0 & count_o >= irq_level_i) | (~empty_o & (rd_perr_o | rd_ferr_o)).

## Timing
- Reset values: rx_en_o=0, rts_no=1 (state OFF), count_o=0, empty_o=1, full_o=0, overrun_o=0, err_cnt_o=0, irq_o=0, rd_data_o/rd_perr_o/rd_ferr_o=0. Pointers reset to 0; memory contents are not reset.
- rx_en_o follows cfg_rx_en_i with 1 cycle latency.
- Push: an entry is visible on rd_data_o, and count_o/empty_o/full_o update, at the edge that samples rx_valid_i.
- Pop: the next head appears at the edge that samples rd_en_i.
- rts_no changes 1 cycle after count_o crosses a watermark. The receiver may still deliver in-flight frames, so RTS_HI leaves DEPTH-RTS_HI entries of slack.
- irq_o lags its sources by 1 cycle.
- Reset asserted mid-operation returns every register to its reset value immediately. A partially received frame is lost.

## Test plan
- cfg_rx_en_i=1, push 12 bytes 0x01..0x0C with no pops -> rts_no=0 two cycles after enable; count_o=12; rts_no rises 1 cycle later. Pop down to 4 -> rts_no falls 1 cycle after count_o=4.
- Fill 16 bytes, then send a 17th byte 0xAA -> dropped, overrun_o=1, irq_o=1 next cycle. Read all -> 0x01..0x10 in order. clr_overrun_i -> overrun_o=0.
- Full FIFO with rd_en_i and rx_valid_i (0x55) in the same cycle -> count_o stays 16, overrun_o=0, 0x55 is read last.
- Push 0x3C with parity_err_i=1 -> rd_perr_o=1 at head, err_cnt_o=1, irq_o=1. After 300 error frames with pops interleaved -> err_cnt_o=255.
- flush_i coincident with rx_valid_i when count_o=5 -> count_o=0, empty_o=1, overrun_o unchanged, rd_data_o=0.
- Deassert reset_n with count_o=7 and rts_no=1 -> all outputs return to reset values asynchronously. After release, rx_en_o stays 0 until cfg_rx_en_i is sampled.
